// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Define MDU_DIV_EN to build the divider; without it DIV/DIVU behave as no-ops.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MDU_DIV_EN
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
`endif
  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] res_q, res_d;
  logic        skip_q, skip_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;

  // Product: sign-extend to 64 bits for MULT, zero-extend for MULTU
  logic        mul_signed_s;
  logic [63:0] mul_a_s, mul_b_s, mul_res_s;

  assign mul_signed_s = ~op[0];
  assign mul_a_s      = {{32{mul_signed_s & A[31]}}, A};
  assign mul_b_s      = {{32{mul_signed_s & B[31]}}, B};
  assign mul_res_s    = mul_a_s * mul_b_s;

  logic [63:0] div_res_s;
  logic        div_zero_s;

`ifdef MDU_DIV_EN
  // Signed divide runs on magnitudes; quotient truncates toward zero, remainder follows dividend
  logic        div_signed_s, a_neg_s, b_neg_s;
  logic [31:0] a_mag_s, b_mag_s, b_safe_s;
  logic [31:0] quo_mag_s, rem_mag_s, quo_s, rem_s;

  assign div_signed_s = ~op[0];
  assign a_neg_s      = div_signed_s & A[31];
  assign b_neg_s      = div_signed_s & B[31];
  assign a_mag_s      = a_neg_s ? (32'd0 - A) : A;
  assign b_mag_s      = b_neg_s ? (32'd0 - B) : B;
  assign div_zero_s   = (B == 32'd0);
  assign b_safe_s     = div_zero_s ? 32'd1 : b_mag_s;
  assign quo_mag_s    = a_mag_s / b_safe_s;
  assign rem_mag_s    = a_mag_s % b_safe_s;
  assign quo_s        = (a_neg_s ^ b_neg_s) ? (32'd0 - quo_mag_s) : quo_mag_s;
  assign rem_s        = a_neg_s ? (32'd0 - rem_mag_s) : rem_mag_s;
  assign div_res_s    = {rem_s, quo_s};
`else
  assign div_res_s    = 64'd0;
  assign div_zero_s   = 1'b0;
`endif

  // Next-state: accept work in IDLE, count down in RUN, commit shadow on the last edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    skip_d  = skip_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU
`ifdef MDU_DIV_EN
            , OP_DIV, OP_DIVU
`endif
            : begin
              res_d   = op[1] ? div_res_s : mul_res_s;
              cnt_d   = op[1] ? DIV_CNT : MULT_CNT;
              skip_d  = op[1] & div_zero_s;
              state_d = ST_RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          if (!skip_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    busy_d = (state_d == ST_RUN);
  end

  // State and architectural registers; reset discards any in-flight operation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      res_q   <= 64'd0;
      skip_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      skip_q  <= skip_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Multi-cycle multiply/divide unit for the MIPS datapath, sitting beside the single-cycle ALU in the EX stage. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO and owns the architectural HI/LO registers. The `busy` output lets the hazard unit stall MFHI/MFLO and further MDU instructions.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU (range 1..15).
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU (range 1..15).

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe; sampled at a rising edge.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
- `A`  in  32  rs operand: multiplicand/dividend, or data for MTHI/MTLO.
- `B`  in  32  rt operand: multiplier/divisor.
- `busy`  out  1  operation in flight.
- `HI`  out  32  architectural HI register.
- `LO`  out  32  architectural LO register.

## Operation
- Two states: IDLE and RUN. There is a 4-bit down-counter `cnt` and a 64-bit result shadow `{res_hi,res_lo}`.
- IDLE, `start`=1, op MULT/MULTU/DIV/DIVU:
  - Compute the result from A/B at that edge and store it in the shadow.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- IDLE, `start`=1, op MTHI: HI <= A at that edge. MTLO: LO <= A. Stay IDLE, no busy cycle.
- IDLE, `start`=1, op 110/111: no effect.
- RUN: decrement `cnt` every edge. At the edge where `cnt` goes 1 -> 0:
  - HI <= res_hi, LO <= res_lo.
  - Return to IDLE.
- `start` while busy (any op, including MTHI/MTLO) is ignored. No queueing; the pipeline must stall it.
- Arithmetic:
  - MULT: 64-bit signed product of A and B. MULTU: unsigned product. HI = bits [63:32], LO = bits [31:0].
  - DIV: signed. LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0x00000000, with no trap.
  - Divisor 0: full DIV_CYCLES busy period runs, then HI and LO keep their prior values (commit suppressed).
- Reset (asserted low) at any time, including mid-RUN:
  - Immediately HI=0, LO=0, busy=0, state=IDLE, cnt=0, shadow=0.
  - The in-flight operation is discarded.

## Timing
- Reset values: `busy`=0, `HI`=0x00000000, `LO`=0x00000000.
- `busy` is a registered output equal to (state==RUN). No combinational path from `start` to `busy`.
- Start accepted at edge E0:
  - `busy`=1 from just after E0 until just after E(N), where N = MULT_CYCLES or DIV_CYCLES.
  - HI/LO change at E(N), the same edge on which busy falls.
  - Results are visible in the first cycle `busy`=0.
- Back-to-back: a `start` held in the first cycle after busy falls is accepted at E(N+1). There is no dead cycle.
- MTHI/MTLO: HI/LO change at the accepting edge, latency 1, never busy.
- HI/LO stay stable throughout RUN until the commit edge. MFHI during busy sees the old value; stalling is the hazard unit's job.
- `A`, `B` and `op` only need to be valid at the accepting edge.

## Configuration
- `MDU_DIV_EN` defined: DIV/DIVU are implemented as above.
- `MDU_DIV_EN` undefined:
  - The divider logic is not synthesized.
  - `start` with op 010/011 is a no-op, like 110/111: busy stays 0 and HI/LO are unchanged.
  - MULT/MULTU/MTHI/MTLO are unaffected.

## Test plan
- MULT A=0xFFFFFFFF, B=0x00000002 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=0x00000002 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 on consecutive cycles -> HI/LO update one edge each, busy never rises. Then DIVU with B=0 -> busy 10 cycles, HI/LO unchanged.
- During a MULT (busy=1), pulse start with MTLO A=0xDEADBEEF and with DIV -> both ignored; only the MULT result commits, after exactly 5 cycles.
- Reset: drive reset low in cycle 3 of a DIV -> busy, HI and LO go to 0 immediately without waiting for a clock edge. Release reset; a new MULT A=3, B=4 -> HI=0, LO=12 after 5 cycles.
- With `MDU_DIV_EN` undefined: DIV A=10, B=2 -> busy stays 0 and HI/LO are unchanged. Back-to-back MULTs issued the cycle busy falls are both accepted.
